div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
- Consumes the operands EX receives from the ID/EX pipeline register.
- EX holds `start` high and requests a pipeline stall until `ready` rises, then writes `result` to HI/LO.
- Supports signed and unsigned operation, divide-by-zero detection, and cancellation on pipeline flush.

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_unit_step.sv | 26 ++
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle radix-2 restoring divider.
// State encodings and the handshake levels used on start/ready.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
// Purely combinational; the iteration state lives in div_unit.
module div_unit_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  bit_i,
  input  logic [DATA_WIDTH-1:0] dvs_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  q_o
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;
  logic                borrow;

  // rem_i < dvs_i always, so shifted < 2*dvs_i and the (W+1)-bit difference
  // has its top bit set exactly when the subtraction borrows.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, dvs_i};
  assign borrow  = diff[DATA_WIDTH];

  assign q_o   = ~borrow;
  assign rem_o = borrow ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// DIV/DIVU divider for the EX stage: sign-magnitude restoring algorithm,
// one quotient bit per cycle, held result until EX drops start.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    signed_div,
  input  logic [DATA_WIDTH-1:0]   operand1,
  input  logic [DATA_WIDTH-1:0]   operand2,
  input  logic                    start,
  input  logic                    cancel,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    ready
);

  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(DATA_WIDTH);

  div_state_e              state_q, state_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   dvd_q, dvd_d;   // dividend magnitude, becomes the quotient
  logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic                    qsign_q, qsign_d;
  logic                    rsign_q, rsign_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic                    ready_q, ready_d;

  logic [DATA_WIDTH-1:0]   step_rem;
  logic                    step_q;
  logic [DATA_WIDTH-1:0]   quo_fix, rem_fix;

  div_unit_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[MSB]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign quo_fix = qsign_q ? (~dvd_q + 1'b1) : dvd_q;
  assign rem_fix = rsign_q ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      DIV_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (!cancel && start == DIV_START) begin
          if (operand2 == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d = DIV_ON;
            cnt_d   = '0;
            dvd_d   = (signed_div && operand1[MSB]) ? (~operand1 + 1'b1) : operand1;
            dvs_d   = (signed_div && operand2[MSB]) ? (~operand2 + 1'b1) : operand2;
            qsign_d = signed_div & (operand1[MSB] ^ operand2[MSB]);
            rsign_d = signed_div & operand1[MSB];
            rem_d   = '0;
          end
        end
      end
      DIV_BY_ZERO: begin
        state_d  = DIV_END;
        result_d = '0;
      end
      DIV_ON: begin
        if (cancel) begin
          state_d  = DIV_FREE;
          cnt_d    = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end else if (cnt_q != LAST) begin
          rem_d = step_rem;
          dvd_d = {dvd_q[MSB-1:0], step_q};
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d  = DIV_END;
          cnt_d    = '0;
          result_d = {rem_fix, quo_fix};
          ready_d  = DIV_RESULT_READY;
        end
      end
      DIV_END: begin
        if (start == DIV_STOP || cancel) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end else begin
          // Divide-by-zero arrives here with ready still low; raise it now.
          ready_d = DIV_RESULT_READY;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: expected {rem,quo} and latency queued at
// issue, popped when ready rises; plus cancel, reset and start/cancel cases.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        signed_div;
  logic [31:0] operand1, operand2;
  logic        start, cancel;
  logic [63:0] result;
  logic        ready;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  div_unit #(.DATA_WIDTH(32), .COUNT_WIDTH(6)) dut (
    .clock      (clk),
    .reset      (reset),
    .signed_div (signed_div),
    .operand1   (operand1),
    .operand2   (operand2),
    .start      (start),
    .cancel     (cancel),
    .result     (result),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Issue one divide, wait (bounded) for ready, compare, check hold and clear.
  task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    logic [63:0] e;
    int el, n;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    @(negedge clk);
    signed_div = sgn; operand1 = a; operand2 = b; start = 1'b1;
    @(posedge clk); #1;
    operand1 = $urandom; operand2 = $urandom; signed_div = 1'($urandom);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    chk({tag, ".lat"}, 64'(n), 64'(el));
    chk({tag, ".res"}, result, e);
    @(posedge clk); #1;
    chk({tag, ".hold_rdy"}, 64'(ready), 64'd1);
    chk({tag, ".hold_res"}, result, e);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".clr_rdy"}, 64'(ready), 64'd0);
    chk({tag, ".clr_res"}, result, 64'h0);
  endtask

  initial begin
    int seen;
    logic [31:0] ra, rb;
    bit rs;
    reset = 1'b1; signed_div = 1'b0; operand1 = '0; operand2 = '0;
    start = 1'b0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy", 64'(ready), 64'd0);
    chk("rst.res", result, 64'h0);
    @(negedge clk); reset = 1'b0;

    run_op("u100_7",  1'b0, 32'd100,        32'd7,          {32'h2, 32'hE}, 33);
    run_op("s-7_2",   1'b1, 32'hFFFF_FFF9,  32'h2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_op("u-7_2",   1'b0, 32'hFFFF_FFF9,  32'h2,          {32'h1, 32'h7FFF_FFFC}, 33);
    run_op("div0",    1'b1, 32'h1234_5678,  32'h0,          64'h0, 2);
    run_op("s_ovf",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000}, 33);
    run_op("u_max_1", 1'b0, 32'hFFFF_FFFF,  32'h1,          {32'h0, 32'hFFFF_FFFF}, 33);
    run_op("s7_-2",   1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h1, 32'hFFFF_FFFD}, 33);

    // Cancel on the 10th ON cycle; EX flush also drops start.
    @(negedge clk); signed_div = 1'b0; operand1 = 32'd100; operand2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk); cancel = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("cancel.rdy", 64'(ready), 64'd0);
    @(negedge clk); cancel = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ready) seen++; end
    chk("cancel.never", 64'(seen), 64'd0);
    run_op("u9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

    // start and cancel together in FREE: nothing starts (divisor 0 would be quick).
    @(negedge clk); operand1 = 32'd5; operand2 = 32'd0; start = 1'b1; cancel = 1'b1;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (ready) seen++; end
    chk("stcan.none", 64'(seen), 64'd0);

    // Async reset mid-ON, between edges.
    @(negedge clk); signed_div = 1'b0; operand1 = 32'd1000; operand2 = 32'd3; start = 1'b1;
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_on.rdy", 64'(ready), 64'd0);
    chk("rst_on.res", result, 64'h0);
    @(negedge clk); reset = 1'b0; start = 1'b0;
    run_op("post_rst", 1'b0, 32'd1000, 32'd3, {32'h1, 32'd333}, 33);

    // Async reset while END is holding a nonzero result.
    @(negedge clk); signed_div = 1'b0; operand1 = 32'd100; operand2 = 32'd7; start = 1'b1;
    seen = 0;
    while (!ready && seen < 100) begin @(posedge clk); #1; seen++; end
    chk("rst_end.pre", result, {32'h2, 32'hE});
    #2 reset = 1'b1;
    #1;
    chk("rst_end.rdy", 64'(ready), 64'd0);
    chk("rst_end.res", result, 64'h0);
    @(negedge clk); reset = 1'b0; start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      rs = 1'(i);
      ra = $urandom;
      rb = (i == 4) ? 32'(ra >> 7) | 32'h1 : $urandom_range(1, 32'hFFFF);
      if (i == 5) rb = -rb;
      run_op($sformatf("rnd%0d", i), rs, ra, rb, model(rs, ra, rb), 33);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
